// File: rtl/cplx_alu.sv
// cplx_alu: signed fixed-point complex add / multiply / accumulate / |a|^2 unit.
// One command at a time, one shared W x W multiplier, saturated complex result.
module cplx_alu #(
  parameter int W = 16,
  parameter int F = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic                acc_clr,
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  output logic                res_valid,
  input  logic                res_ready,
  output logic signed [W-1:0] res_re,
  output logic signed [W-1:0] res_im,
  output logic                ovf
);

  localparam int SW = 2 * W + 2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_ABS = 2'b11;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ADD   = 4'd1;
  localparam logic [3:0] S_M_RR  = 4'd2;
  localparam logic [3:0] S_M_II  = 4'd3;
  localparam logic [3:0] S_M_RI  = 4'd4;
  localparam logic [3:0] S_M_IR  = 4'd5;
  localparam logic [3:0] S_AB_RR = 4'd6;
  localparam logic [3:0] S_AB_II = 4'd7;
  localparam logic [3:0] S_OUT   = 4'd8;

  logic [3:0]          state;
  logic [1:0]          op_q;
  logic                clr_q;
  logic signed [W-1:0] ar, ai, br, bi;
  logic signed [W-1:0] acc_re, acc_im;
  logic signed [SW-1:0] sr, si;

  logic signed [W-1:0]   mx, my;
  logic signed [2*W-1:0] prod;
  logic signed [SW-1:0]  prod_x;
  logic signed [W-1:0]   base_re, base_im;
  logic signed [SW-1:0]  add_re, add_im;
  logic signed [SW-1:0]  fin_re, fin_im;
  logic [W:0]            sat_re, sat_im;

  function automatic logic signed [SW-1:0] sx(input logic signed [W-1:0] v);
    return {{(SW-W){v[W-1]}}, v};
  endfunction

  // Returns {clamped, value} for a wide signed input.
  function automatic logic [W:0] sat(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] hi, lo;
    hi = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    lo = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};
    if (x > hi)      return {1'b1, hi[W-1:0]};
    else if (x < lo) return {1'b1, lo[W-1:0]};
    else             return {1'b0, x[W-1:0]};
  endfunction

  assign cmd_ready = (state == S_IDLE) && !rst;

  // Operand selection for the single shared multiplier.
  always_comb begin
    mx = ar;
    my = br;
    case (state)
      S_M_II:  begin mx = ai; my = bi; end
      S_M_RI:  begin mx = ar; my = bi; end
      S_M_IR:  begin mx = ai; my = br; end
      S_AB_RR: begin mx = ar; my = ar; end
      S_AB_II: begin mx = ai; my = ai; end
      default: begin mx = ar; my = br; end
    endcase
  end

  assign prod   = mx * my;
  assign prod_x = {{2{prod[2*W-1]}}, prod};

  // Add/accumulate sums and final scaling + saturation of the wide sums.
  always_comb begin
    base_re = br;
    base_im = bi;
    if (op_q == OP_ACC) begin
      base_re = clr_q ? '0 : acc_re;
      base_im = clr_q ? '0 : acc_im;
    end
    add_re = sx(base_re) + sx(ar);
    add_im = sx(base_im) + sx(ai);
    fin_re = sr;
    fin_im = si;
    if (op_q == OP_MUL || op_q == OP_ABS) begin
      fin_re = sr >>> F;
      fin_im = si >>> F;
    end
    sat_re = sat(fin_re);
    sat_im = sat(fin_im);
  end

  // Control FSM and datapath registers.
  // The first OUT cycle forms the saturated result and raises res_valid;
  // this extra cycle is what gives every op its latency of (compute states + 1).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_ADD;
      clr_q     <= 1'b0;
      ar        <= '0;
      ai        <= '0;
      br        <= '0;
      bi        <= '0;
      sr        <= '0;
      si        <= '0;
      acc_re    <= '0;
      acc_im    <= '0;
      res_valid <= 1'b0;
      res_re    <= '0;
      res_im    <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            clr_q <= acc_clr;
            ar    <= a_re;
            ai    <= a_im;
            br    <= b_re;
            bi    <= b_im;
            case (cmd_op)
              OP_MUL:  state <= S_M_RR;
              OP_ABS:  state <= S_AB_RR;
              default: state <= S_ADD;
            endcase
          end
        end
        S_ADD: begin
          sr    <= add_re;
          si    <= add_im;
          state <= S_OUT;
        end
        S_M_RR: begin
          sr    <= prod_x;
          state <= S_M_II;
        end
        S_M_II: begin
          sr    <= sr - prod_x;
          state <= S_M_RI;
        end
        S_M_RI: begin
          si    <= prod_x;
          state <= S_M_IR;
        end
        S_M_IR: begin
          si    <= si + prod_x;
          state <= S_OUT;
        end
        S_AB_RR: begin
          sr    <= prod_x;
          si    <= '0;
          state <= S_AB_II;
        end
        S_AB_II: begin
          sr    <= sr + prod_x;
          state <= S_OUT;
        end
        S_OUT: begin
          if (!res_valid) begin
            res_re    <= sat_re[W-1:0];
            res_im    <= sat_im[W-1:0];
            ovf       <= sat_re[W] | sat_im[W];
            res_valid <= 1'b1;
            if (op_q == OP_ACC) begin
              acc_re <= sat_re[W-1:0];
              acc_im <= sat_im[W-1:0];
            end
          end else if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cplx_alu.sv
// Self-checking bench for cplx_alu: scoreboard queue of expected results,
// one task per scenario.
module tb_cplx_alu;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic               acc_clr;
  logic signed [15:0] a_re, a_im, b_re, b_im;
  logic               res_valid;
  logic               res_ready;
  logic signed [15:0] res_re, res_im;
  logic               ovf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic               ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  cplx_alu #(.W(16), .F(14)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .acc_clr(acc_clr),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_re(res_re), .res_im(res_im), .ovf(ovf)
  );

  // Issue one command, check latency, pop and compare the result,
  // hold res_ready low for 'stall' cycles, then complete the handshake.
  task automatic do_cmd(input string name, input logic [1:0] op, input logic clr,
                        input logic signed [15:0] ar, input logic signed [15:0] ai,
                        input logic signed [15:0] br, input logic signed [15:0] bi,
                        input logic signed [15:0] ere, input logic signed [15:0] eim,
                        input logic eovf, input int lat, input int stall);
    exp_t e;
    int   cnt;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_before: cmd_ready=%b want 1", name, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; acc_clr = clr;
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    sb.push_back('{re: ere, im: eim, ovf: eovf});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); acc_clr = 1'($urandom);
    a_re = 16'($urandom); a_im = 16'($urandom); b_re = 16'($urandom); b_im = 16'($urandom);
    cnt = 0;
    while (res_valid !== 1'b1 && cnt < 20) begin
      checks++;
      if (cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s_busy_ready: cmd_ready=%b want 0 at cycle %0d", name, cmd_ready, cnt);
      end
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt !== lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d want %0d", name, cnt, lat);
    end
    e = sb.pop_front();
    checks++;
    if (res_re !== e.re || res_im !== e.im || ovf !== e.ovf) begin
      failures++;
      $display("FAIL %s_result: got (%0d,%0d) ovf=%b want (%0d,%0d) ovf=%b",
               name, res_re, res_im, ovf, e.re, e.im, e.ovf);
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || cmd_ready !== 1'b0 || res_re !== e.re ||
          res_im !== e.im || ovf !== e.ovf) begin
        failures++;
        $display("FAIL %s_stall%0d: valid=%b ready=%b (%0d,%0d) ovf=%b want valid=1 ready=0 (%0d,%0d) ovf=%b",
                 name, i, res_valid, cmd_ready, res_re, res_im, ovf, e.re, e.im, e.ovf);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || res_re !== e.re || res_im !== e.im) begin
      failures++;
      $display("FAIL %s_handshake: valid=%b ready=%b (%0d,%0d) want valid=0 ready=1 (%0d,%0d)",
               name, res_valid, cmd_ready, res_re, res_im, e.re, e.im);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; acc_clr = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; res_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b0 || res_re !== 16'sd0 || res_im !== 16'sd0 ||
          ovf !== 1'b0 || cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_values: valid=%b re=%0d im=%0d ovf=%b ready=%b want all 0",
                 res_valid, res_re, res_im, ovf, cmd_ready);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: cmd_ready=%b want 1", cmd_ready);
    end
  endtask

  task automatic test_mul();
    do_cmd("mul_j", 2'b01, 1'b0, 16'sd16384, 16'sd0, 16'sd0, 16'sd16384,
           16'sd0, 16'sd16384, 1'b0, 5, 0);
    do_cmd("mul_floor", 2'b01, 1'b0, -16'sd1, 16'sd0, 16'sd1, 16'sd0,
           -16'sd1, 16'sd0, 1'b0, 5, 0);
    // (0.5+0.25j)(0.5-0.5j) = 0.375-0.125j
    do_cmd("mul_mixed", 2'b01, 1'b0, 16'sd8192, 16'sd4096, 16'sd8192, -16'sd8192,
           16'sd6144, -16'sd2048, 1'b0, 5, 0);
  endtask

  task automatic test_mul_sat();
    do_cmd("mul_sat", 2'b01, 1'b0, -16'sd32768, 16'sd0, -16'sd32768, 16'sd0,
           16'sd32767, 16'sd0, 1'b1, 5, 0);
  endtask

  task automatic test_add_sat();
    do_cmd("add_sat", 2'b00, 1'b0, 16'sd30000, -16'sd30000, 16'sd10000, -16'sd10000,
           16'sd32767, -16'sd32768, 1'b1, 2, 0);
    do_cmd("add_plain", 2'b00, 1'b0, 16'sd123, -16'sd456, -16'sd23, 16'sd56,
           16'sd100, -16'sd400, 1'b0, 2, 0);
  endtask

  task automatic test_abs();
    do_cmd("abs", 2'b11, 1'b0, 16'sd8192, 16'sd8192, 16'sd1111, 16'sd2222,
           16'sd8192, 16'sd0, 1'b0, 3, 0);
    // 1.5^2 + 1.5^2 = 4.5 -> clamps
    do_cmd("abs_sat", 2'b11, 1'b0, 16'sd24576, -16'sd24576, 16'sd0, 16'sd0,
           16'sd32767, 16'sd0, 1'b1, 3, 0);
  endtask

  task automatic test_acc_backpressure();
    do_cmd("acc_clr", 2'b10, 1'b1, 16'sd100, -16'sd50, 16'sd7, 16'sd7,
           16'sd100, -16'sd50, 1'b0, 2, 0);
    do_cmd("acc_bp", 2'b10, 1'b0, 16'sd20, 16'sd20, -16'sd9, 16'sd9,
           16'sd120, -16'sd30, 1'b0, 2, 3);
    // Saturated value is what the accumulator keeps.
    do_cmd("acc_sat", 2'b10, 1'b0, 16'sd32767, 16'sd0, 16'sd0, 16'sd0,
           16'sd32767, -16'sd30, 1'b1, 2, 0);
    do_cmd("acc_after_sat", 2'b10, 1'b0, -16'sd767, 16'sd30, 16'sd0, 16'sd0,
           16'sd32000, 16'sd0, 1'b0, 2, 0);
  endtask

  task automatic test_reset_mid();
    do_cmd("acc_pre", 2'b10, 1'b1, 16'sd7, 16'sd7, 16'sd0, 16'sd0,
           16'sd7, 16'sd7, 1'b0, 2, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01;
    a_re = 16'sd16384; a_im = 16'sd100; b_re = 16'sd16384; b_im = 16'sd200;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b0 || res_re !== 16'sd0 ||
          res_im !== 16'sd0 || ovf !== 1'b0) begin
        failures++;
        $display("FAIL midreset_values: valid=%b ready=%b re=%0d im=%0d ovf=%b want all 0",
                 res_valid, cmd_ready, res_re, res_im, ovf);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL midreset_abort%0d: valid=%b ready=%b want valid=0 ready=1",
                 i, res_valid, cmd_ready);
      end
    end
    do_cmd("acc_post_reset", 2'b10, 1'b0, 16'sd5, 16'sd5, 16'sd0, 16'sd0,
           16'sd5, 16'sd5, 1'b0, 2, 0);
  endtask

  // cmd_valid held high while busy must not be captured afterwards.
  task automatic test_back_to_back();
    exp_t e;
    int   cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; acc_clr = 1'b0;
    a_re = 16'sd1; a_im = 16'sd2; b_re = 16'sd3; b_im = 16'sd4;
    sb.push_back('{re: 16'sd4, im: 16'sd6, ovf: 1'b0});
    @(posedge clk); #1;
    cmd_op = 2'b01; a_re = 16'sd999; b_re = 16'sd999;
    res_ready = 1'b1;
    cnt = 0;
    while (res_valid !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt !== 2) begin
      failures++;
      $display("FAIL b2b_latency: got %0d want 2", cnt);
    end
    e = sb.pop_front();
    checks++;
    if (res_re !== e.re || res_im !== e.im || ovf !== e.ovf) begin
      failures++;
      $display("FAIL b2b_result: got (%0d,%0d) ovf=%b want (%0d,%0d) ovf=%b",
               res_re, res_im, ovf, e.re, e.im, e.ovf);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_handshake: valid=%b ready=%b want valid=0 ready=1", res_valid, cmd_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_no_capture%0d: valid=%b ready=%b want valid=0 ready=1",
                 i, res_valid, cmd_ready);
      end
    end
    do_cmd("b2b_next", 2'b00, 1'b0, -16'sd10, 16'sd10, -16'sd20, 16'sd20,
           -16'sd30, 16'sd30, 1'b0, 2, 0);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_sat();
    test_add_sat();
    test_abs();
    test_acc_backpressure();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_empty: %0d left want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
